// File: rtl/nn_pkg.sv
// Shared widths and FSM state encoding for the dense layer with argmax.
package nn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    CMP  = 2'd2,
    DONE = 2'd3
  } nn_state_e;

  // Accumulator holds NUM_IN products plus the bias without overflow.
  function automatic int unsigned acc_width(input int unsigned in_w, input int unsigned w_w,
                                            input int unsigned num_in);
    return in_w + w_w + int'($clog2(num_in + 1));
  endfunction

  function automatic int unsigned idx_width(input int unsigned num_neurons);
    return (num_neurons > 1) ? int'($clog2(num_neurons)) : 1;
  endfunction

  function automatic int unsigned waddr_width(input int unsigned num_in,
                                              input int unsigned num_neurons);
    return int'($clog2(num_neurons * (num_in + 1)));
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Registered signed multiply-accumulate with synchronous clear.
module mac_unit #(
  parameter int unsigned IN_W  = 12,
  parameter int unsigned W_W   = 12,
  parameter int unsigned ACC_W = 26
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [IN_W-1:0]  x,
  input  logic signed [W_W-1:0]   w,
  output logic signed [ACC_W-1:0] acc
);

  localparam int unsigned PROD_W = IN_W + W_W;

  logic signed [PROD_W-1:0] prod_c;

  assign prod_c = PROD_W'(x) * PROD_W'(w);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_W'(prod_c);
    end
  end

endmodule

// File: rtl/dense_layer_argmax.sv
// Time-multiplexed fully-connected layer: one shared MAC walks every neuron,
// optional ReLU, and the strict-greater argmax keeps the lowest index on ties.
module dense_layer_argmax
  import nn_pkg::*;
#(
  parameter int unsigned NUM_IN      = 3,
  parameter int unsigned NUM_NEURONS = 5,
  parameter int unsigned IN_W        = 12,
  parameter int unsigned W_W         = 12,
  parameter int unsigned RELU        = 1,
  localparam int unsigned ACC_W = acc_width(IN_W, W_W, NUM_IN),
  localparam int unsigned IDX_W = idx_width(NUM_NEURONS),
  localparam int unsigned WA_W  = waddr_width(NUM_IN, NUM_NEURONS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN*IN_W-1:0]   in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     w_we,
  input  logic [WA_W-1:0]          w_addr,
  input  logic signed [W_W-1:0]    w_data,
  output logic signed [ACC_W-1:0]  out_max,
  output logic [IDX_W-1:0]         out_idx,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int unsigned DEPTH = NUM_NEURONS * (NUM_IN + 1);
  localparam int unsigned K_W   = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam logic [WA_W:0]    DEPTH_W = (WA_W + 1)'(DEPTH);
  localparam logic [K_W-1:0]   K_LAST  = K_W'(NUM_IN - 1);
  localparam logic [IDX_W-1:0] N_LAST  = IDX_W'(NUM_NEURONS - 1);

  nn_state_e               state;
  logic signed [IN_W-1:0]  x_q [NUM_IN];
  logic signed [W_W-1:0]   w_mem [DEPTH];
  logic [WA_W-1:0]         rd_ptr;
  logic [K_W-1:0]          k_q;
  logic [IDX_W-1:0]        n_q;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] best_q;
  logic [IDX_W-1:0]        best_idx_q;
  logic signed [W_W-1:0]   w_rd_c;
  logic signed [ACC_W-1:0] act_c;
  logic signed [ACC_W-1:0] relu_c;
  logic                    take_c;
  logic signed [ACC_W-1:0] win_max_c;
  logic [IDX_W-1:0]        win_idx_c;

  // Weight/bias store; only IDLE writes to in-range addresses land.
  always_ff @(posedge clk) begin
    if (w_we && (state == IDLE) && ({1'b0, w_addr} < DEPTH_W)) begin
      w_mem[w_addr] <= w_data;
    end
  end

  // Weights and bias of a neuron are contiguous, so one pointer walks MAC and CMP reads.
  assign w_rd_c = w_mem[rd_ptr];

  mac_unit #(
    .IN_W  (IN_W),
    .W_W   (W_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (state != MAC),
    .en  (state == MAC),
    .x   (x_q[k_q]),
    .w   (w_rd_c),
    .acc (acc)
  );

  always_comb begin
    act_c  = acc + ACC_W'(w_rd_c);
    relu_c = act_c;
    if ((RELU != 0) && act_c[ACC_W-1]) begin
      relu_c = '0;
    end
    take_c    = (n_q == '0) || (relu_c > best_q);
    win_max_c = take_c ? relu_c : best_q;
    win_idx_c = take_c ? n_q : best_idx_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_max    <= '0;
      out_idx    <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      n_q        <= '0;
      k_q        <= '0;
      rd_ptr     <= '0;
      for (int i = 0; i < int'(NUM_IN); i++) begin
        x_q[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            for (int i = 0; i < int'(NUM_IN); i++) begin
              x_q[i] <= in_data[i*IN_W +: IN_W];
            end
            n_q      <= '0;
            k_q      <= '0;
            rd_ptr   <= '0;
            in_ready <= 1'b0;
            state    <= MAC;
          end
        end
        MAC: begin
          rd_ptr <= rd_ptr + WA_W'(1);
          if (k_q == K_LAST) begin
            k_q   <= '0;
            state <= CMP;
          end else begin
            k_q <= k_q + K_W'(1);
          end
        end
        CMP: begin
          rd_ptr     <= rd_ptr + WA_W'(1);
          best_q     <= win_max_c;
          best_idx_q <= win_idx_c;
          k_q        <= '0;
          if (n_q == N_LAST) begin
            out_max   <= win_max_c;
            out_idx   <= win_idx_c;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            n_q   <= n_q + IDX_W'(1);
            state <= MAC;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_layer_argmax.sv
// Scoreboard bench: a ReLU and a raw-compare instance run in lockstep on shared stimulus.
module tb_dense_layer_argmax;

  localparam int NI    = 3;
  localparam int NN    = 5;
  localparam int DEPTH = NN * (NI + 1);
  localparam int LAT   = NN * (NI + 1);

  typedef struct {
    longint mx1;
    longint ix1;
    longint mx0;
    longint ix0;
  } exp_t;

  logic              clk;
  logic              rst;
  logic [NI*12-1:0]  in_data;
  logic              in_valid;
  logic              w_we;
  logic [4:0]        w_addr;
  logic signed [11:0] w_data;
  logic              out_ready;
  logic              in_ready1, in_ready0;
  logic              out_valid1, out_valid0;
  logic signed [25:0] out_max1, out_max0;
  logic [2:0]        out_idx1, out_idx0;

  int   total = 0;
  int   bad   = 0;
  int   wm [DEPTH];
  exp_t sb [$];

  dense_layer_argmax #(.NUM_IN(NI), .NUM_NEURONS(NN), .IN_W(12), .W_W(12), .RELU(1)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .out_max(out_max1), .out_idx(out_idx1),
    .out_valid(out_valid1), .out_ready(out_ready)
  );

  dense_layer_argmax #(.NUM_IN(NI), .NUM_NEURONS(NN), .IN_W(12), .W_W(12), .RELU(0)) dut_raw (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready0),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .out_max(out_max0), .out_idx(out_idx0),
    .out_valid(out_valid0), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1);
  end

  task automatic check_val(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic load_w(input int addr, input int val);
    w_we   = 1'b1;
    w_addr = 5'(addr);
    w_data = 12'(val);
    wm[addr] = val;
    @(negedge clk);
    w_we = 1'b0;
  endtask

  // Reference: plain dot products, then argmax with lowest index on ties.
  task automatic push_expect(input int x0, input int x1, input int x2);
    int     xv [NI];
    longint a, a1, b1, b0;
    exp_t   e;
    xv = '{x0, x1, x2};
    b1 = 0; b0 = 0;
    e = '{0, 0, 0, 0};
    for (int n = 0; n < NN; n++) begin
      a = longint'(wm[n*(NI+1) + NI]);
      for (int k = 0; k < NI; k++) a += longint'(xv[k]) * longint'(wm[n*(NI+1) + k]);
      a1 = (a < 0) ? 0 : a;
      if (n == 0 || a1 > b1) begin b1 = a1; e.ix1 = n; end
      if (n == 0 || a > b0) begin b0 = a; e.ix0 = n; end
    end
    e.mx1 = b1;
    e.mx0 = b0;
    sb.push_back(e);
  endtask

  task automatic wait_ready();
    int cnt = 0;
    while (!in_ready1 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check_val("in_ready_idle", longint'(in_ready1), 1);
  endtask

  task automatic drive_vec(input int x0, input int x1, input int x2);
    int xv [NI];
    xv = '{x0, x1, x2};
    for (int k = 0; k < NI; k++) in_data[k*12 +: 12] = 12'(xv[k]);
    in_valid = 1'b1;
  endtask

  task automatic run_vec(input int x0, input int x1, input int x2, input int hold,
                         input bit busy_wr, input bit same_wr, input int sa, input int sd);
    int   cnt;
    exp_t e;
    wait_ready();
    drive_vec(x0, x1, x2);
    if (same_wr) begin
      w_we = 1'b1; w_addr = 5'(sa); w_data = 12'(sd); wm[sa] = sd;
    end
    push_expect(x0, x1, x2);
    @(negedge clk);
    in_valid = 1'b0;
    w_we = 1'b0;
    check_val("busy_in_ready", longint'(in_ready1), 0);
    cnt = 0;
    while (!out_valid1 && cnt < 200) begin
      w_we = busy_wr && (cnt == 2);
      w_addr = 5'd16;
      w_data = 12'(-100);
      @(negedge clk);
      cnt++;
    end
    w_we = 1'b0;
    check_val("latency", cnt, LAT);
    check_val("raw_valid", longint'(out_valid0), longint'(out_valid1));
    if (out_valid1) begin
      check_val("sb_size", sb.size(), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_val("max_relu", longint'(out_max1), e.mx1);
        check_val("idx_relu", longint'(out_idx1), e.ix1);
        check_val("max_raw", longint'(out_max0), e.mx0);
        check_val("idx_raw", longint'(out_idx0), e.ix0);
        for (int i = 0; i < hold; i++) begin
          @(negedge clk);
          check_val("hold_valid", longint'(out_valid1), 1);
          check_val("hold_max", longint'(out_max1), e.mx1);
          check_val("hold_idx", longint'(out_idx1), e.ix1);
          check_val("hold_in_ready", longint'(in_ready1), 0);
        end
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check_val("post_hs_valid", longint'(out_valid1), 0);
      check_val("post_hs_in_ready", longint'(in_ready1), 1);
    end
  endtask

  initial begin
    int cnt;
    rst = 1'b0; in_valid = 1'b0; in_data = '0; w_we = 1'b0; w_addr = '0; w_data = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_valid", longint'(out_valid1), 0);
    check_val("rst_in_ready", longint'(in_ready1), 0);
    check_val("rst_max", longint'(out_max1), 0);
    check_val("rst_idx", longint'(out_idx1), 0);
    rst = 1'b1;
    @(negedge clk);

    // w[n][0]=n, rest zero; a write during MAC must be dropped
    for (int a = 0; a < DEPTH; a++) load_w(a, ((a % (NI+1)) == 0) ? a / (NI+1) : 0);
    run_vec(10, 0, 0, 0, 1'b1, 1'b0, 0, 0);
    run_vec(10, 0, 0, 10, 1'b0, 1'b0, 0, 0);
    run_vec(10, 0, 0, 2, 1'b0, 1'b1, 4, 50);

    for (int a = 0; a < DEPTH; a++) load_w(a, ((a % (NI+1)) == NI) ? 0 : 1);
    run_vec(1, 2, 3, 1, 1'b0, 1'b0, 0, 0);

    for (int a = 0; a < DEPTH; a++) load_w(a, ((a % (NI+1)) == NI) ? 0 : -1);
    run_vec(1, 1, 1, 0, 1'b0, 1'b0, 0, 0);

    for (int a = 0; a < DEPTH; a++) load_w(a, 0);
    for (int k = 0; k < NI; k++) load_w(2*(NI+1) + k, -2048);
    load_w(2*(NI+1) + NI, 2047);
    run_vec(-2048, -2048, -2048, 0, 1'b0, 1'b0, 0, 0);

    // Reset in the middle of MAC discards the vector
    wait_ready();
    drive_vec(5, 6, 7);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("midrst_valid", longint'(out_valid1), 0);
    check_val("midrst_in_ready", longint'(in_ready1), 0);
    check_val("midrst_max", longint'(out_max1), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_val("postrst_in_ready", longint'(in_ready1), 1);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid1) cnt++;
    end
    check_val("postrst_no_valid", cnt, 0);
    run_vec(-2048, -2048, -2048, 1, 1'b0, 1'b0, 0, 0);

    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < DEPTH; a++) load_w(a, int'($urandom_range(0, 4095)) - 2048);
      run_vec(int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048,
              int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 3)),
              1'b0, 1'b0, 0, 0);
    end

    check_val("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
